// File: rtl/ahfp_pkg.sv
// Shared constants for the ahfp delay line and its result FIFO, plus a clog2 helper.
package ahfp_pkg;

   localparam int unsigned AHFP_WIDTH  = 32;
   localparam int unsigned AHFP_STAGES = 10;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((32'd1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/ahfp_valid_chain.sv
// Valid token shift register mirroring the ahfp delay line latency.
module ahfp_valid_chain
   import ahfp_pkg::*;
#(
   parameter int unsigned STAGES = AHFP_STAGES
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr <= '0;
      end else begin
         sr[0] <= d;
         for (int unsigned i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
      end
   end

   assign q = sr[STAGES-1];

endmodule

// File: rtl/ahfp_result_fifo.sv
// Captures ahfp delay line results into a credit-protected FWFT FIFO with a ready/valid port.
module ahfp_result_fifo
   import ahfp_pkg::*;
#(
   parameter int unsigned WIDTH  = AHFP_WIDTH,
   parameter int unsigned STAGES = AHFP_STAGES,
   parameter int unsigned DEPTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue,
   output logic                    issue_ok,
   input  logic [WIDTH-1:0]        in_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_data,
   output logic [clog2(DEPTH):0]   level,
   output logic                    err
);

   localparam int unsigned PW = clog2(DEPTH);
   localparam int unsigned LW = PW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [LW-1:0]    reserved;
   logic             acc;
   logic             pop;
   logic             push;
   logic             full;
   logic             wr_en;

   // Credits cover both in-flight tokens and stored entries, so a push always has room.
   assign issue_ok  = (reserved < LW'(DEPTH));
   assign acc       = issue & issue_ok;
   assign out_valid = (level != '0);
   assign pop       = out_valid & out_ready;
   assign full      = (level == LW'(DEPTH));
   assign wr_en     = push & (~full | pop);
   assign out_data  = mem[rd_ptr];

   ahfp_valid_chain #(.STAGES(STAGES)) u_vchain (
      .clk (clk),
      .rst (rst),
      .d   (acc),
      .q   (push)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         reserved <= '0;
         err      <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         level    <= level + LW'(wr_en) - LW'(pop);
         reserved <= reserved + LW'(acc) - LW'(pop);
         if ((issue & ~issue_ok) | (push & ~wr_en)) err <= 1'b1;
      end
   end

   // Storage is intentionally not reset; contents are only observed behind out_valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= in_data;
   end

endmodule

// File: tb/tb_ahfp_result_fifo.sv
// Randomized bench for ahfp_result_fifo against a queue-based model and a model delay line.
module tb_ahfp_result_fifo;
   import ahfp_pkg::*;

   localparam int unsigned WIDTH  = AHFP_WIDTH;
   localparam int unsigned STAGES = AHFP_STAGES;
   localparam int unsigned DEPTH  = 16;
   localparam int unsigned LW     = clog2(DEPTH) + 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             issue;
   logic             issue_ok;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [LW-1:0]    level;
   logic             err;

   logic [WIDTH-1:0] operand;
   logic [WIDTH-1:0] dl [STAGES];

   typedef struct {
      int               due;
      logic [WIDTH-1:0] d;
   } pend_t;

   pend_t            pend[$];
   logic [WIDTH-1:0] mq[$];
   bit               m_err;
   int               cyc;
   int               total;
   int               bad;

   ahfp_result_fifo #(.WIDTH(WIDTH), .STAGES(STAGES), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .issue     (issue),
      .issue_ok  (issue_ok),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .level     (level),
      .err       (err)
   );

   always #5 clk = ~clk;

   function automatic bit m_ok();
      return (pend.size() + mq.size()) < DEPTH;
   endfunction

   // One clock: apply model rules for the edge, then advance the upstream delay line.
   task automatic step();
      bit ok;
      @(posedge clk);
      cyc++;
      ok = m_ok();
      if (issue && !ok) m_err = 1'b1;
      if (out_ready && mq.size() != 0) void'(mq.pop_front());
      if (pend.size() != 0 && pend[0].due == cyc) begin
         if (mq.size() == DEPTH) m_err = 1'b1;
         else mq.push_back(pend[0].d);
         void'(pend.pop_front());
      end
      if (issue && ok) pend.push_back('{cyc + int'(STAGES), operand});
      #1;
      for (int i = int'(STAGES) - 1; i > 0; i--) dl[i] = dl[i-1];
      dl[0]   = operand;
      in_data = dl[STAGES-1];
   endtask

   task automatic model_reset();
      pend.delete();
      mq.delete();
      m_err = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; issue = 1'b0; out_ready = 1'b0; operand = '0; in_data = '0;
      for (int i = 0; i < int'(STAGES); i++) dl[i] = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL reset_issue_ok got=%0b exp=1", issue_ok); end
      total++; if (level !== LW'(0)) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err); end
   endtask

   task automatic test_single();
      int n;
      issue = 1'b1; operand = 32'h3F80_0000;
      step();
      issue = 1'b0; operand = $urandom;
      n = 0;
      while (out_valid !== 1'b1 && n < int'(STAGES) + 5) begin
         step();
         operand = $urandom;
         n++;
      end
      total++; if (n != int'(STAGES)) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", n, STAGES); end
      total++; if (out_data !== 32'h3F80_0000) begin bad++; $display("FAIL single_data got=%h exp=3f800000", out_data); end
      total++; if (level !== LW'(1)) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_drain got=%0b exp=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         issue = 1'b1; operand = WIDTH'(i);
         step();
         total++;
         if (issue_ok !== (i != int'(DEPTH) - 1)) begin
            bad++; $display("FAIL b2b_issue_ok i=%0d got=%0b exp=%0b", i, issue_ok, (i != int'(DEPTH) - 1));
         end
      end
      issue = 1'b0; operand = $urandom;
      repeat (STAGES) begin step(); operand = $urandom; end
      total++; if (level !== LW'(DEPTH)) begin bad++; $display("FAIL b2b_level got=%0d exp=%0d", level, DEPTH); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL b2b_err got=%0b exp=0", err); end
      total++; if (issue_ok !== 1'b0) begin bad++; $display("FAIL b2b_blocked got=%0b exp=0", issue_ok); end
   endtask

   task automatic test_credit_return();
      total++; if (out_data !== WIDTH'(0)) begin bad++; $display("FAIL credit_head got=%h exp=0", out_data); end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL credit_issue_ok got=%0b exp=1", issue_ok); end
      total++; if (level !== LW'(DEPTH - 1)) begin bad++; $display("FAIL credit_level got=%0d exp=%0d", level, DEPTH - 1); end
      out_ready = 1'b1;
      for (int k = 1; k < int'(DEPTH); k++) begin
         total++; if (out_data !== WIDTH'(k)) begin bad++; $display("FAIL credit_order k=%0d got=%h exp=%h", k, out_data, WIDTH'(k)); end
         step();
      end
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL credit_empty got=%0b exp=0", out_valid); end
   endtask

   task automatic test_stream();
      for (int c = 0; c < 300; c++) begin
         issue     = ($urandom_range(3) != 0) && issue_ok;
         out_ready = (c < 120) ? ($urandom_range(2) == 0) : ($urandom_range(7) != 0);
         operand   = $urandom;
         step();
         total++; if (out_valid !== (mq.size() != 0)) begin bad++; $display("FAIL stream_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, mq.size() != 0); end
         total++; if (level !== LW'(mq.size())) begin bad++; $display("FAIL stream_level cyc=%0d got=%0d exp=%0d", cyc, level, mq.size()); end
         total++; if (issue_ok !== m_ok()) begin bad++; $display("FAIL stream_issue_ok cyc=%0d got=%0b exp=%0b", cyc, issue_ok, m_ok()); end
         total++; if (err !== m_err) begin bad++; $display("FAIL stream_err cyc=%0d got=%0b exp=%0b", cyc, err, m_err); end
         if (mq.size() != 0) begin
            total++; if (out_data !== mq[0]) begin bad++; $display("FAIL stream_data cyc=%0d got=%h exp=%h", cyc, out_data, mq[0]); end
         end
      end
      issue = 1'b0;
   endtask

   task automatic test_violation();
      int n;
      logic [LW-1:0] lvl;
      out_ready = 1'b0; issue = 1'b1;
      n = 0;
      while (issue_ok === 1'b1 && n < int'(DEPTH) + 4) begin operand = $urandom; step(); n++; end
      issue = 1'b0;
      total++; if (issue_ok !== 1'b0) begin bad++; $display("FAIL viol_fill got=%0b exp=0", issue_ok); end
      repeat (STAGES + 1) begin operand = $urandom; step(); end
      lvl = level;
      total++; if (level !== LW'(DEPTH)) begin bad++; $display("FAIL viol_full got=%0d exp=%0d", level, DEPTH); end
      issue = 1'b1; operand = $urandom;
      step();
      issue = 1'b0;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL viol_err got=%0b exp=1", err); end
      repeat (STAGES + 2) begin operand = $urandom; step(); end
      total++; if (level !== lvl) begin bad++; $display("FAIL viol_level got=%0d exp=%0d", level, lvl); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL viol_sticky got=%0b exp=1", err); end
      total++; if (level !== LW'(mq.size())) begin bad++; $display("FAIL viol_model got=%0d exp=%0d", level, mq.size()); end
   endtask

   task automatic test_reset_midflight();
      rst = 1'b1; #1; rst = 1'b0; model_reset();
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin issue = 1'b1; operand = $urandom; step(); end
      issue = 1'b0;
      repeat (STAGES) begin operand = $urandom; step(); end
      for (int i = 0; i < 5; i++) begin issue = 1'b1; operand = $urandom; step(); end
      issue = 1'b0;
      total++; if (level !== LW'(3)) begin bad++; $display("FAIL mid_prelevel got=%0d exp=3", level); end
      #3 rst = 1'b1;
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_async_valid got=%0b exp=0", out_valid); end
      total++; if (level !== LW'(0)) begin bad++; $display("FAIL mid_async_level got=%0d exp=0", level); end
      total++; if (err !== 1'b0) begin bad++; $display("FAIL mid_async_err got=%0b exp=0", err); end
      model_reset();
      @(posedge clk); #1 rst = 1'b0;
      for (int c = 0; c < int'(STAGES) + 3; c++) begin
         operand = $urandom;
         step();
         total++; if (level !== LW'(0) || out_valid !== 1'b0) begin bad++; $display("FAIL mid_nopush c=%0d level=%0d valid=%0b exp level=0 valid=0", c, level, out_valid); end
      end
      total++; if (issue_ok !== 1'b1) begin bad++; $display("FAIL mid_issue_ok got=%0b exp=1", issue_ok); end
   endtask

   initial begin
      total = 0; bad = 0; cyc = 0;
      test_reset();
      test_single();
      test_back_to_back();
      test_credit_return();
      test_stream();
      test_violation();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
